// File: rtl/residual_add_scaled.sv
// residual_add_scaled
//   Closing add of an Inception-ResNet block. Skip pixels are buffered in a
//   small FIFO until the matching branch pixel arrives. The branch pixel is
//   scaled by a runtime residual factor, added to the skip pixel with
//   saturation, and optionally passed through ReLU. Fixed 2-cycle latency,
//   one pixel per cycle, no backpressure.
//
// Ports
//   clk        : clock
//   reset      : synchronous active-low reset
//   valid_in_1 : skip pixel valid (FIFO push)
//   pxl_in_1   : skip pixel
//   valid_in_2 : branch pixel valid (FIFO pop request)
//   pxl_in_2   : branch pixel
//   scale      : residual scale factor, same Q format as the pixels
//   pxl_out    : result pixel, holds while valid_out is low
//   valid_out  : result valid, one pulse per result
//   done       : pulses with the last valid_out of a frame
//   sat        : pulses with a valid_out whose result saturated in any stage
//   overflow   : sticky, a skip push was dropped on a full FIFO
//   underflow  : sticky, a branch pixel was dropped on an empty FIFO
module residual_add_scaled #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int SKIP_DEPTH = 64,
    parameter int IMG_SIZE   = 17,
    parameter int RELU_EN    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in_1,
    input  logic [DATA_WIDTH-1:0] pxl_in_1,
    input  logic                  valid_in_2,
    input  logic [DATA_WIDTH-1:0] pxl_in_2,
    input  logic [DATA_WIDTH-1:0] scale,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  done,
    output logic                  sat,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int AW    = $clog2(SKIP_DEPTH);
    localparam int CNTW  = AW + 1;
    localparam int FRAME = IMG_SIZE * IMG_SIZE;
    localparam int FCW   = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int PW    = 2 * DATA_WIDTH + 1;

    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(SKIP_DEPTH);
    localparam logic [FCW-1:0]  LAST_PIX = FCW'(FRAME - 1);

    // Half an output LSB for round-half-up; collapses to 0 when FRAC_BITS==0.
    localparam logic signed [PW-1:0] RND   = PW'((PW'(1) << FRAC_BITS) >> 1);
    localparam logic signed [PW-1:0] S_MAX = {{(DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] S_MIN = {{(DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] D_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] D_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // ---------------------------------------------------------------- FIFO
    logic [DATA_WIDTH-1:0] mem_q [SKIP_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]       count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  empty, full, push, pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign pop   = valid_in_2 && !empty;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign push  = valid_in_1 && (!full || pop);

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
        overflow_d  = overflow_q  || (valid_in_1 && full && !pop);
        underflow_d = underflow_q || (valid_in_2 && empty);
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= pxl_in_1;
        end
    end

    // ------------------------------------------------------- S1: scaling
    logic signed [2*DATA_WIDTH-1:0] br_ext, sc_ext, prod;
    logic signed [PW-1:0]           prod_rnd, prod_sh;
    logic [DATA_WIDTH-1:0]          scaled_d;
    logic                           sat1_d;

    assign br_ext   = {{DATA_WIDTH{pxl_in_2[DATA_WIDTH-1]}}, pxl_in_2};
    assign sc_ext   = {{DATA_WIDTH{scale[DATA_WIDTH-1]}}, scale};
    assign prod     = br_ext * sc_ext;
    // One guard bit so the rounding add can never wrap.
    assign prod_rnd = $signed({prod[2*DATA_WIDTH-1], prod}) + RND;
    assign prod_sh  = prod_rnd >>> FRAC_BITS;

    always_comb begin
        scaled_d = prod_sh[DATA_WIDTH-1:0];
        sat1_d   = 1'b0;
        if (prod_sh > S_MAX) begin
            scaled_d = D_MAX;
            sat1_d   = 1'b1;
        end else if (prod_sh < S_MIN) begin
            scaled_d = D_MIN;
            sat1_d   = 1'b1;
        end
    end

    logic                  v1_q;
    logic [DATA_WIDTH-1:0] skip1_q, scaled1_q;
    logic                  sat1_q;

    // ---------------------------------------------------------- S2: add
    logic signed [DATA_WIDTH:0] sum;
    logic                       add_sat;
    logic [DATA_WIDTH-1:0]      sum_sat, res;

    assign sum     = $signed({skip1_q[DATA_WIDTH-1], skip1_q})
                   + $signed({scaled1_q[DATA_WIDTH-1], scaled1_q});
    assign add_sat = sum[DATA_WIDTH] ^ sum[DATA_WIDTH-1];

    always_comb begin
        sum_sat = sum[DATA_WIDTH-1:0];
        if (add_sat) begin
            sum_sat = sum[DATA_WIDTH] ? D_MIN : D_MAX;
        end
        // ReLU clamping is deliberately not reported as saturation.
        res = sum_sat;
        if ((RELU_EN != 0) && sum_sat[DATA_WIDTH-1]) begin
            res = '0;
        end
    end

    logic [DATA_WIDTH-1:0] pxl_out_q, pxl_out_d;
    logic                  valid_out_q, done_q, done_d, sat_q;
    logic [FCW-1:0]        frame_cnt_q, frame_cnt_d;

    always_comb begin
        pxl_out_d   = v1_q ? res : pxl_out_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        if (v1_q) begin
            if (frame_cnt_q == LAST_PIX) begin
                frame_cnt_d = '0;
                done_d      = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + FCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            v1_q        <= 1'b0;
            skip1_q     <= '0;
            scaled1_q   <= '0;
            sat1_q      <= 1'b0;
            pxl_out_q   <= '0;
            valid_out_q <= 1'b0;
            done_q      <= 1'b0;
            sat_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            v1_q        <= pop;
            if (pop) begin
                skip1_q   <= mem_q[rd_ptr_q];
                scaled1_q <= scaled_d;
                sat1_q    <= sat1_d;
            end
            pxl_out_q   <= pxl_out_d;
            valid_out_q <= v1_q;
            done_q      <= done_d;
            sat_q       <= v1_q && (sat1_q || add_sat);
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign pxl_out   = pxl_out_q;
    assign valid_out = valid_out_q;
    assign done      = done_q;
    assign sat       = sat_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: doc/residual_add_scaled.md
Name: residual_add_scaled

Overview:
- Parametrised successor of the residual "mach cong" add stage that closes an Inception-ResNet block.
- Buffers the skip stream in an internal FIFO until the late branch stream arrives.
- Scales each branch pixel by a runtime residual scale factor, adds it to the matching skip pixel with saturation, and optionally applies ReLU.
- Reports FIFO overflow/underflow, saturation, and end of frame.

Parameters:
- DATA_WIDTH, 32, pixel width; signed two's-complement fixed point.
- FRAC_BITS, 16, fractional bits of pixels and scale (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS); range 0..DATA_WIDTH-2.
- SKIP_DEPTH, 64, skip FIFO depth in pixels; power of two, ≥2.
- IMG_SIZE, 17, feature-map side length; a frame is IMG_SIZE*IMG_SIZE output pixels.
- RELU_EN, 1, 1 = ReLU on output, 0 = linear output.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- valid_in_1  in  1  skip pixel valid (push).
- pxl_in_1  in  DATA_WIDTH  skip pixel.
- valid_in_2  in  1  branch pixel valid (pop request).
- pxl_in_2  in  DATA_WIDTH  branch pixel.
- scale  in  DATA_WIDTH  residual scale factor, same Q format; quasi-static, sampled each accepted pair.
- pxl_out  out  DATA_WIDTH  result pixel.
- valid_out  out  1  result valid, 1-cycle pulse per result.
- done  out  1  1-cycle pulse coincident with the last valid_out of a frame.
- sat  out  1  1-cycle pulse coincident with a valid_out whose result saturated in any stage.
- overflow  out  1  sticky; a skip push was dropped because the FIFO was full.
- underflow  out  1  sticky; a branch pixel was dropped because the FIFO was empty.

Behaviour:
- Reset (sampled on clk edge, reset==0):
  - Clears FIFO pointers and count, pipeline valids, and the pixel counter.
  - Drives pxl_out=0; valid_out, done, sat, overflow and underflow =0.
  - Reset mid-frame discards all buffered and in-flight data; no valid_out in the cycle after reset.
- Skip FIFO:
  - Push when valid_in_1=1.
  - Pop when valid_in_2=1 and count>0. There is no bypass: a pixel pushed in cycle T is poppable from T+1.
  - Full and push without pop: push dropped, overflow←1.
  - Full with simultaneous push and pop: both occur, count unchanged, no overflow.
  - valid_in_2=1 with count==0: branch pixel dropped, underflow←1, no output. This holds even when a push occurs in the same cycle; the push still lands.
  - Pointers wrap modulo SKIP_DEPTH.
- Pipeline (accepted pair in cycle T):
  - S1, register at T+1:
    - prod = pxl_in_2 * scale, full 2*DATA_WIDTH signed.
    - Add 2^(FRAC_BITS-1) when FRAC_BITS>0 (round half up), then arithmetic shift right FRAC_BITS.
    - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
    - Registers the popped skip and a sat1 bit.
  - S2, register at T+2:
    - sum = skip + scaled, computed at DATA_WIDTH+1 bits and saturated to DATA_WIDTH.
    - If RELU_EN and sum<0, output 0.
    - pxl_out and valid_out are registered here.
    - sat = sat1 OR add saturation. ReLU clamping is not saturation.
- Latency: fixed 2 cycles from accepted pair to valid_out. Throughput: 1 pixel/cycle. No backpressure.
- pxl_out holds its last value while valid_out=0.
- Frame counter:
  - Counts valid_out, 0..IMG_SIZE*IMG_SIZE-1.
  - On the final count, done=1 in the same cycle and the counter wraps to 0.
  - Consecutive frames need no idle gap.
- overflow and underflow clear only on reset.

Test Plan:
- Basic (Q16.16, RELU_EN=1): push skip 0x00010000; next cycle branch 0x00020000 with scale 0x00008000 (0.5) → two cycles later pxl_out=0x00020000, valid_out=1, sat=0.
- Saturation: skip 0x7FFF0000, branch 0x00040000, scale 0x00010000 → pxl_out=0x7FFFFFFF, sat=1. Branch 0x40000000 × scale 0x00040000 saturates in S1 → sat=1.
- ReLU mode: skip 0xFFFD0000 (-3.0), branch 0x00010000, scale 0x00010000 → RELU_EN=1 gives 0x00000000; RELU_EN=0 gives 0xFFFE0000; sat=0 in both.
- FIFO limits (SKIP_DEPTH=4):
  - Push 5 skips (1..5) with no branch → overflow=1.
  - 4 branches of 0 with scale 1.0 → outputs 1,2,3,4.
  - A 5th branch → no output, underflow=1.
  - Full FIFO with simultaneous push and pop → no overflow.
- Frame/streaming (IMG_SIZE=2, skip leading branch by 3 cycles, continuous):
  - done pulses on every 4th valid_out with no gap between frames.
  - Latency stays 2 cycles.
- Reset mid-operation: 3 skips buffered and 1 pair in flight, assert reset=0 for 1 cycle → no valid_out afterwards; flags 0; the next pair uses only newly pushed skips; the frame count restarts at 0.
